// File: rtl/instr_mem_arb.sv
// instr_mem_arb: arbitrates a fetch port and a debug/loader port onto a
// single-ported instruction memory. The memory reads on the falling edge, so
// a request granted at posedge k returns data at posedge k+1.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   f_req/f_addr/f_flush         fetch request, word address, flush in-flight fetches
//   f_gnt                        fetch accepted this cycle (combinational)
//   f_vld/f_instr/f_err          fetch response (one-cycle vld pulse)
//   d_req/d_addr/d_gnt           debug request/address/accept
//   d_vld/d_data/d_err           debug response
//   im_rd_en/im_addr/im_instr    instruction memory interface
module instr_mem_arb #(
  parameter int DEPTH        = 16384,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  input  logic        f_flush,
  output logic        f_gnt,
  output logic        f_vld,
  output logic [15:0] f_instr,
  output logic        f_err,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  output logic        d_gnt,
  output logic        d_vld,
  output logic [15:0] d_data,
  output logic        d_err,
  output logic        im_rd_en,
  output logic [15:0] im_addr,
  input  logic [15:0] im_instr
);

  localparam int          CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic {ARB, FORCE_D} state_t;

  // port: 0 = fetch, 1 = debug
  typedef struct packed {
    logic vld;
    logic port;
    logic err;
  } tag_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  tag_t [1:0]      tag_pipe;
  tag_t            tag0_d, tag1_d;
  logic            gnt_any, oor;
  logic [15:0]     sel_addr;

  // Arbitration and starvation tracking
  always_comb begin
    f_gnt   = 1'b0;
    d_gnt   = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst_n) begin
      case (state_q)
        ARB: begin
          f_gnt = f_req;
          d_gnt = d_req & ~f_req;
          if (!d_req || d_gnt)  cnt_d = '0;
          else if (f_gnt)       cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(STARVE_LIMIT)) state_d = FORCE_D;
        end
        FORCE_D: begin
          // one forced debug slot; if debug already gave up, nothing is granted
          d_gnt   = d_req;
          cnt_d   = '0;
          state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  assign gnt_any  = f_gnt | d_gnt;
  assign sel_addr = d_gnt ? d_addr : f_addr;
  assign oor      = ({1'b0, sel_addr} >= DEPTH_W);

  // Tag pipeline. A flush seen at the grant edge kills the fetch being
  // granted; a flush seen one edge later kills the fetch already issued.
  always_comb begin
    tag0_d.vld  = gnt_any & ~(f_gnt & f_flush);
    tag0_d.port = d_gnt;
    tag0_d.err  = oor;
    tag1_d      = tag_pipe[0];
    tag1_d.vld  = tag_pipe[0].vld & ~(f_flush & ~tag_pipe[0].port);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      cnt_q    <= '0;
      tag_pipe <= '0;
      im_rd_en <= 1'b0;
      im_addr  <= '0;
      f_instr  <= '0;
      d_data   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tag_pipe[0] <= tag0_d;
      tag_pipe[1] <= tag1_d;
      im_rd_en    <= gnt_any & ~oor;
      if (gnt_any && !oor) im_addr <= sel_addr;
      // data registers only move when their port responds
      if (tag1_d.vld && !tag1_d.port) f_instr <= tag1_d.err ? 16'h0000 : im_instr;
      if (tag1_d.vld &&  tag1_d.port) d_data  <= tag1_d.err ? 16'h0000 : im_instr;
    end
  end

  assign f_vld = tag_pipe[1].vld & ~tag_pipe[1].port;
  assign d_vld = tag_pipe[1].vld &  tag_pipe[1].port;
  assign f_err = f_vld & tag_pipe[1].err;
  assign d_err = d_vld & tag_pipe[1].err;

endmodule

// File: tb/tb_instr_mem_arb.sv
module tb_instr_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, f_flush, d_req;
  logic [15:0] f_addr, d_addr;
  logic        f_gnt, f_vld, f_err, d_gnt, d_vld, d_err, im_rd_en;
  logic [15:0] f_instr, d_data, im_addr;
  logic [15:0] im_instr = 16'h0;

  int checks   = 0;
  int failures = 0;

  instr_mem_arb dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_gnt(f_gnt),
    .f_vld(f_vld), .f_instr(f_instr), .f_err(f_err),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
    .d_vld(d_vld), .d_data(d_data), .d_err(d_err),
    .im_rd_en(im_rd_en), .im_addr(im_addr), .im_instr(im_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == 16'h0010) return 16'hA5C3;
    return (a * 16'h03B1) ^ 16'h1234;
  endfunction

  // memory model: reads on the falling edge
  always @(negedge clk) if (im_rd_en) im_instr <= memf(im_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; f_req = 1'b1; d_req = 1'b1; f_flush = 1'b0;
    f_addr = 16'h0010; d_addr = 16'h0020;
    #2;
    chk("rst_f_gnt", f_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_im_rd_en", im_rd_en, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_vlds", {f_vld, d_vld, f_err, d_err}, 0);
    chk("rst_data", {f_instr, d_data}, 0);
    step();
    rst_n = 1'b1; f_req = 1'b0; d_req = 1'b0;
    step();

    // fetch alone
    f_req = 1'b1; f_addr = 16'h0010; #1;
    chk("fa_f_gnt", f_gnt, 1);
    chk("fa_d_gnt", d_gnt, 0);
    step(); f_req = 1'b0;
    chk("fa_rd_en", im_rd_en, 1);
    chk("fa_im_addr", im_addr, 16'h0010);
    chk("fa_vld_early", f_vld, 0);
    step();
    chk("fa_vld", f_vld, 1);
    chk("fa_instr", f_instr, 16'hA5C3);
    chk("fa_err", f_err, 0);
    chk("fa_rd_en_off", im_rd_en, 0);
    step();
    chk("fa_vld_pulse", f_vld, 0);
    chk("fa_instr_hold", f_instr, 16'hA5C3);

    // contention: F,F,F,F,D repeating
    f_req = 1'b1; d_req = 1'b1; f_addr = 16'h0030; d_addr = 16'h0100;
    begin
      logic pf, pd;
      pf = 1'b0; pd = 1'b0;
      for (int i = 0; i < 10; i++) begin
        #1;
        chk($sformatf("ct_f_gnt%0d", i), f_gnt, (i % 5) != 4);
        chk($sformatf("ct_d_gnt%0d", i), d_gnt, (i % 5) == 4);
        step();
        chk($sformatf("ct_f_vld%0d", i), f_vld, pf);
        chk($sformatf("ct_d_vld%0d", i), d_vld, pd);
        if (pf) chk("ct_f_instr", f_instr, memf(16'h0030));
        if (pd) chk("ct_d_data", d_data, memf(16'h0100));
        pf = (i % 5) != 4;
        pd = (i % 5) == 4;
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    step(); chk("ct_last_d_vld", d_vld, 1);
    chk("ct_last_d_data", d_data, memf(16'h0100));
    step();

    // out of range on the debug port
    d_req = 1'b1; d_addr = 16'h4000; #1;
    chk("oor_d_gnt", d_gnt, 1);
    step(); d_req = 1'b0;
    chk("oor_rd_en", im_rd_en, 0);
    chk("oor_im_addr_hold", im_addr, 16'h0100);
    step();
    chk("oor_d_vld", d_vld, 1);
    chk("oor_d_err", d_err, 1);
    chk("oor_d_data", d_data, 16'h0000);
    chk("oor_f_vld", f_vld, 0);
    step();
    chk("oor_d_vld_pulse", {d_vld, d_err}, 0);

    // flush after issue
    f_req = 1'b1; f_addr = 16'h0020;
    step(); f_addr = 16'h0021;
    step(); f_req = 1'b0; f_flush = 1'b1;
    chk("fl_vld20", f_vld, 1);
    chk("fl_instr20", f_instr, memf(16'h0020));
    step(); f_flush = 1'b0;
    chk("fl_vld21_killed", f_vld, 0);
    chk("fl_instr_hold", f_instr, memf(16'h0020));
    f_req = 1'b1; f_addr = 16'h0022;
    step(); f_req = 1'b0;
    step();
    chk("fl_next_vld", f_vld, 1);
    chk("fl_next_instr", f_instr, memf(16'h0022));
    // flush in the same cycle as the grant
    f_req = 1'b1; f_addr = 16'h0023; f_flush = 1'b1; #1;
    chk("fl_same_gnt", f_gnt, 1);
    step(); f_req = 1'b0; f_flush = 1'b0;
    step();
    chk("fl_same_killed", f_vld, 0);
    // debug responses ignore flush
    d_req = 1'b1; d_addr = 16'h0040;
    step(); d_req = 1'b0; f_flush = 1'b1;
    step(); f_flush = 1'b0;
    chk("fl_dbg_vld", d_vld, 1);
    chk("fl_dbg_data", d_data, memf(16'h0040));
    step();

    // reset with a read in flight
    f_req = 1'b1; f_addr = 16'h0050;
    step(); f_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rm_rd_en", im_rd_en, 0);
    chk("rm_im_addr", im_addr, 0);
    chk("rm_vlds", {f_vld, d_vld, f_err, d_err}, 0);
    chk("rm_data", {f_instr, d_data}, 0);
    #3 rst_n = 1'b1;
    step();
    chk("rm_no_vld1", {f_vld, d_vld}, 0);
    step();
    chk("rm_no_vld2", {f_vld, d_vld}, 0);

    // random mixed traffic
    begin
      logic        pf, pd, pe, fg, dg;
      logic [15:0] pa;
      pf = 1'b0; pd = 1'b0; pe = 1'b0; pa = '0;
      for (int i = 0; i < 1000; i++) begin
        f_req = 1'($urandom_range(0, 1));
        d_req = 1'($urandom_range(0, 1));
        f_addr = ($urandom_range(0, 7) == 0) ? 16'h4000 | 16'($urandom_range(0, 16'h3FFF))
                                             : 16'($urandom_range(0, 16383));
        d_addr = ($urandom_range(0, 7) == 0) ? 16'hC000 | 16'($urandom_range(0, 16'h3FFF))
                                             : 16'($urandom_range(0, 16383));
        #1;
        fg = f_gnt; dg = d_gnt;
        chk("rnd_both_gnt", fg & dg, 0);
        chk("rnd_gnt_no_req", (fg & ~f_req) | (dg & ~d_req), 0);
        step();
        chk("rnd_f_vld", f_vld, pf);
        chk("rnd_d_vld", d_vld, pd);
        if (pf) begin
          chk("rnd_f_err", f_err, pe);
          chk("rnd_f_instr", f_instr, pe ? 16'h0 : memf(pa));
        end
        if (pd) begin
          chk("rnd_d_err", d_err, pe);
          chk("rnd_d_data", d_data, pe ? 16'h0 : memf(pa));
        end
        pf = fg; pd = dg;
        pa = dg ? d_addr : f_addr;
        pe = (pa >= 16'h4000);
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
